popcount_seq_unit: RTL and testbench
====================================

// Module: popcount_seq_unit
// PURPOSE
//  Multi-cycle bit-count unit for the ALU: counts ones (or zeros) in a WIDTH-bit operand,
//  CHUNK bits per cycle, and returns a zero-extended RES_W-bit count.
//  Parametrised, handshaked successor to the single-cycle count-ones ALU op.
//  Sits beside the ALU datapath. The ALU issues on opcode OP_COUNT1/OP_COUNT0 and collects
//  the result via a valid/ready handshake.
// PARAMETERS
//  WIDTH  32  operand width in bits, >=1
//  CHUNK  4   bits counted per cycle, 1..WIDTH
//  RES_W  32  result width; must hold WIDTH (RES_W > $clog2(WIDTH))
// PORTS
//  clk          in   1        rising-edge clock
//  reset_n      in   1        asynchronous active-low reset
//  in_valid     in   1        request present
//  in_ready     out  1        unit can accept a request (high only in IDLE)
//  opcode       in   6        6'b001000=count ones, 6'b001001=count zeros, others illegal
//  operand      in   WIDTH    value to count
//  out_valid    out  1        result valid, held until out_ready
//  out_ready    in   1        consumer accepts result
//  result       out  RES_W    count, zero-extended
//  err_op       out  1        result is from an illegal opcode (valid with out_valid)
//  balance_bit  out  1        only with POPCNT_BALANCE_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0; err_op=0;
//    balance_bit=0; accumulator and step counter=0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: on in_valid&&in_ready, latch operand and mode, clear the accumulator, go BUSY.
//    Illegal opcode: go straight to DONE with result=0 and err_op=1.
//  - BUSY: each cycle add popcount of chunk[s] (bits s*CHUNK.. +CHUNK-1) to the accumulator.
//    STEPS = ceil(WIDTH/CHUNK) cycles. Go DONE after the last step.
//    Count-zeros mode counts inverted operand bits.
//  - Pad bits above WIDTH-1 in the last chunk are counted as 0 in both modes.
//  - DONE: out_valid=1; result/err_op/balance_bit stable. On out_ready, go IDLE
//    (in_ready rises the next cycle).
//  - Latency: accept edge -> out_valid = STEPS+1 cycles for legal ops, 1 cycle for illegal.
//  - out_ready low holds DONE indefinitely. No new request is accepted while BUSY or DONE.
//  - Inputs are sampled only on the accept edge. Operand changes afterwards are ignored.
//  - in_valid is ignored outside IDLE. There is no queueing.
//  - Accumulator width $clog2(WIDTH+1), zero-extended to RES_W. It cannot overflow.
//  - Reset asserted mid-BUSY/DONE aborts: the pending result is lost and out_valid drops at once.
// CONFIGURATION
//  POPCNT_BALANCE_EN defined: balance_bit=1 when result is even, 0 when odd.
//    Registered with result, 0 on illegal op, valid with out_valid.
//  POPCNT_BALANCE_EN undefined: balance_bit port and logic are absent.
//    All other behaviour is identical.
// STRUCTURE
//  Package popcount_pkg holds:
//    state enum {IDLE,BUSY,DONE};
//    OP_COUNT1=6'b001000, OP_COUNT0=6'b001001;
//    function steps(WIDTH,CHUNK).
//  Sub-module popcount_chunk: combinational CHUNK-bit popcount with mask input for pad bits.
//    One instance.
//  Top: FSM, step counter, operand register, accumulator.
// TESTING  (WIDTH=32, CHUNK=4 unless noted)
//  1 op=001000, operand=32'hF0F0_0001 -> result=9, err_op=0; out_valid 9 cycles after accept.
//  2 op=001001, operand=32'hFFFF_FFFF -> result=0; operand=0 -> result=32.
//  3 out_ready low 5 cycles in DONE -> out_valid, result stable, in_ready=0;
//    release -> IDLE, next request accepted.
//  4 op=6'b111111 -> out_valid 1 cycle after accept, result=0, err_op=1.
//  5 reset_n low on BUSY step 3 -> out_valid=0, in_ready=1 immediately;
//    next op result unaffected.
//  6 WIDTH=10, CHUNK=4: op=001001, operand=10'h3FF -> result=0 (pad not counted);
//    with POPCNT_BALANCE_EN, operand=10'h007 op=001000 -> result=3, balance_bit=0.

Source files
------------

// File: rtl/popcount_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : popcount_pkg
// Purpose : Shared FSM states, opcodes and step-count helper for the
//           multi-cycle bit-count unit.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] OP_COUNT1 = 6'b001000;
    localparam logic [5:0] OP_COUNT0 = 6'b001001;

    // Number of CHUNK-wide slices needed to cover WIDTH bits.
    function automatic int steps(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_chunk.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : popcount_chunk
// Purpose : Combinational popcount of one CHUNK-bit slice; masked-off bits
//           (padding above the operand width) never contribute.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module popcount_chunk #(
    parameter int CHUNK = 4,
    parameter int CNT_W = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] data,
    input  logic [CHUNK-1:0] mask,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CNT_W'(data[i] & mask[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/popcount_seq_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : popcount_seq_unit
// Purpose : Handshaked multi-cycle count-ones / count-zeros unit, CHUNK bits
//           per cycle. Optional macro POPCNT_BALANCE_EN adds balance_bit
//           (1 when the result is even).
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module popcount_seq_unit
    import popcount_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             err_op
`ifdef POPCNT_BALANCE_EN
    ,
    output logic             balance_bit
`endif
);

    localparam int STEPS  = steps(WIDTH, CHUNK);
    localparam int PAD_W  = STEPS * CHUNK;
    localparam int ACC_W  = $clog2(WIDTH + 1);
    localparam int CCNT_W = $clog2(CHUNK + 1);
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] c_last_step = STEP_W'(STEPS - 1);

    state_t              r_state;
    logic [PAD_W-1:0]    r_operand;
    logic [ACC_W-1:0]    r_acc;
    logic [STEP_W-1:0]   r_step;
    logic [RES_W-1:0]    r_result;
    logic                r_err;

    logic [PAD_W-1:0]    w_valid_bits;
    logic [CHUNK-1:0]    w_chunk;
    logic [CHUNK-1:0]    w_mask;
    logic [CCNT_W-1:0]   w_cnt;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_accept;
    logic                w_legal;
    logic                w_last;

    // Bits at or above WIDTH are padding and are masked out of every count.
    for (genvar i = 0; i < PAD_W; i++) begin : g_valid_bits
        assign w_valid_bits[i] = (i < WIDTH) ? 1'b1 : 1'b0;
    end

    assign w_chunk    = r_operand[r_step*CHUNK +: CHUNK];
    assign w_mask     = w_valid_bits[r_step*CHUNK +: CHUNK];
    assign w_acc_next = r_acc + ACC_W'(w_cnt);
    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_legal    = (opcode == OP_COUNT1) || (opcode == OP_COUNT0);
    assign w_last     = (r_step == c_last_step);

    popcount_chunk #(
        .CHUNK (CHUNK),
        .CNT_W (CCNT_W)
    ) u_chunk (
        .data  (w_chunk),
        .mask  (w_mask),
        .count (w_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_operand <= '0;
            r_acc     <= '0;
            r_step    <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // Count-zeros is folded into the stored operand so BUSY is mode-agnostic.
                        r_operand <= PAD_W'((opcode == OP_COUNT0) ? ~operand : operand);
                        r_acc     <= '0;
                        r_step    <= '0;
                        r_result  <= '0;
                        r_err     <= !w_legal;
                        r_state   <= w_legal ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_result <= RES_W'(w_acc_next);
                        r_state  <= DONE;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef POPCNT_BALANCE_EN
    logic r_balance;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_balance <= 1'b0;
        end else if (w_accept) begin
            r_balance <= 1'b0;
        end else if ((r_state == BUSY) && w_last) begin
            r_balance <= ~w_acc_next[0];
        end
    end

    assign balance_bit = r_balance;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign err_op    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_popcount_seq_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for popcount_seq_unit: a 32/4 instance and a 10/4 instance
// checked against a $countones-based reference model.
module tb_popcount_seq_unit;

    localparam logic [5:0] C1 = 6'b001000;
    localparam logic [5:0] C0 = 6'b001001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [5:0]  a_opcode = '0;
    logic [31:0] a_operand = '0;
    logic        a_in_ready, a_out_valid, a_err_op, a_balance;
    logic [31:0] a_result;

    logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [5:0]  b_opcode = '0;
    logic [9:0]  b_operand = '0;
    logic        b_in_ready, b_out_valid, b_err_op, b_balance;
    logic [31:0] b_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    popcount_seq_unit #(.WIDTH(32), .CHUNK(4), .RES_W(32)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .opcode     (a_opcode),
        .operand    (a_operand),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .result     (a_result),
        .err_op     (a_err_op)
`ifdef POPCNT_BALANCE_EN
        ,
        .balance_bit(a_balance)
`endif
    );

    popcount_seq_unit #(.WIDTH(10), .CHUNK(4), .RES_W(32)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .opcode     (b_opcode),
        .operand    (b_operand),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .result     (b_result),
        .err_op     (b_err_op)
`ifdef POPCNT_BALANCE_EN
        ,
        .balance_bit(b_balance)
`endif
    );

`ifndef POPCNT_BALANCE_EN
    assign a_balance = 1'b0;
    assign b_balance = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? b_in_ready : a_in_ready;
    endfunction
    function automatic logic ovld(input bit sel);
        return sel ? b_out_valid : a_out_valid;
    endfunction
    function automatic logic [31:0] res(input bit sel);
        return sel ? b_result : a_result;
    endfunction
    function automatic logic err(input bit sel);
        return sel ? b_err_op : a_err_op;
    endfunction
    function automatic logic bal(input bit sel);
        return sel ? b_balance : a_balance;
    endfunction

    // Drive one request through the unit selected by sel and check it end to end.
    task automatic run_op(input bit sel, input logic [5:0] op, input logic [31:0] opnd,
                          input int hold, input string tag);
        int          w;
        logic [31:0] mask, exp_res;
        logic        legal;
        int          exp_lat, lat, n;
        w       = sel ? 10 : 32;
        mask    = sel ? 32'h0000_03FF : 32'hFFFF_FFFF;
        legal   = (op == C1) || (op == C0);
        exp_res = !legal ? 32'd0 :
                  (op == C1) ? 32'($countones(opnd & mask)) : 32'(w - $countones(opnd & mask));
        exp_lat = legal ? ((w + 3) / 4) + 1 : 1;

        n = 0;
        while (!rdy(sel) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_in_ready"}, 64'(rdy(sel)), 64'd1);

        if (sel) begin b_in_valid = 1'b1; b_opcode = op; b_operand = opnd[9:0]; end
        else     begin a_in_valid = 1'b1; a_opcode = op; a_operand = opnd; end
        @(posedge clk); #1;
        // Scramble inputs after accept; they must be ignored.
        if (sel) begin b_in_valid = 1'b1; b_operand = 10'($urandom); b_opcode = 6'($urandom); end
        else     begin a_in_valid = 1'b1; a_operand = $urandom; a_opcode = 6'($urandom); end

        lat = 1;
        while (!ovld(sel) && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(res(sel)), 64'(exp_res));
        check({tag, "_err_op"}, 64'(err(sel)), 64'(!legal));
`ifdef POPCNT_BALANCE_EN
        check({tag, "_balance"}, 64'(bal(sel)), 64'(legal ? ~exp_res[0] : 1'b0));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(ovld(sel)), 64'd1);
            check({tag, "_hold_result"}, 64'(res(sel)), 64'(exp_res));
            check({tag, "_hold_in_ready"}, 64'(rdy(sel)), 64'd0);
        end
        if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
        @(posedge clk); #1;
        if (sel) b_out_ready = 1'b0; else a_out_ready = 1'b0;
        check({tag, "_drop_valid"}, 64'(ovld(sel)), 64'd0);
        check({tag, "_back_idle"}, 64'(rdy(sel)), 64'd1);
    endtask

    initial begin
        logic [5:0] rop;
        int         pick;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(a_in_ready), 64'd1);
        check("reset_out_valid", 64'(a_out_valid), 64'd0);
        check("reset_result", 64'(a_result), 64'd0);
        check("reset_err_op", 64'(a_err_op), 64'd0);
        check("reset_balance", 64'(a_balance), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(1'b0, C1, 32'hF0F0_0001, 0, "t1_ones");
        run_op(1'b0, C0, 32'hFFFF_FFFF, 0, "t2_zeros_all1");
        run_op(1'b0, C0, 32'h0000_0000, 0, "t2_zeros_all0");
        run_op(1'b0, C1, 32'h1234_5678, 5, "t3_hold");
        run_op(1'b0, C0, 32'h8000_0001, 0, "t3_next");
        run_op(1'b0, 6'b111111, 32'hDEAD_BEEF, 0, "t4_illegal");

        // Reset while BUSY: abort must be immediate.
        @(negedge clk);
        a_in_valid = 1'b1; a_opcode = C1; a_operand = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_busy_in_ready", 64'(a_in_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("t5_abort_valid", 64'(a_out_valid), 64'd0);
        check("t5_abort_in_ready", 64'(a_in_ready), 64'd1);
        check("t5_abort_result", 64'(a_result), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(1'b0, C1, 32'h0000_00FF, 0, "t5_after");

        run_op(1'b1, C0, 32'h0000_03FF, 0, "t6_pad_zeros");
        run_op(1'b1, C1, 32'h0000_0007, 0, "t6_ones3");
        run_op(1'b1, C0, 32'h0000_0000, 0, "t6_zeros_all");

        for (int k = 0; k < 24; k++) begin
            pick = $urandom_range(0, 9);
            rop  = (pick < 4) ? C1 : (pick < 8) ? C0 : 6'($urandom);
            run_op(k[0], rop, $urandom, $urandom_range(0, 2), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
